// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage together with the IF/ID pipeline register. It owns
// the program counter, runs a variable-latency request/acknowledge handshake
// towards instruction memory, and presents PC+4 plus the fetched instruction
// to the decode stage. When no fetched instruction is ready, it inserts a
// bubble: Instr = 0 (nop) and Valid = 0.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   PCWrite        hazard unit: 0 freezes the PC
//   IF_ID_Write    hazard unit: 0 holds the IF/ID register
//   IF_Flush       taken branch/jump in ID: squash fetch, redirect the PC
//   branch_target  redirect address, qualified by IF_Flush
//   imem_req       fetch request (decoded from state)
//   imem_addr      fetch address (decoded from state)
//   imem_rdata     instruction word, qualified by imem_ack
//   imem_ack       one-cycle completion strobe for the current request
//   IF_PC          current PC register
//   IF_ID_PC4      PC+4 of the instruction held in IF/ID
//   IF_ID_Instr    instruction held in IF/ID (0 for a bubble)
//   IF_ID_Valid    IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int unsigned            PC_WIDTH    = 32,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PCWrite,
  input  logic                   IF_ID_Write,
  input  logic                   IF_Flush,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ack,
  output logic [PC_WIDTH-1:0]    IF_PC,
  output logic [PC_WIDTH-1:0]    IF_ID_PC4,
  output logic [INSTR_WIDTH-1:0] IF_ID_Instr,
  output logic                   IF_ID_Valid
);

  // START: idle cycle after reset
  // FETCH: request outstanding for pc
  // HOLD : instruction acked but parked until the pipeline advances
  // DROP : request still outstanding after a flush; its data is discarded
  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t                 state_q,      state_d;
  logic [PC_WIDTH-1:0]    pc_q,         pc_d;
  logic [PC_WIDTH-1:0]    redirect_q,   redirect_d;
  logic [PC_WIDTH-1:0]    buf_pc4_q,    buf_pc4_d;
  logic [INSTR_WIDTH-1:0] buf_instr_q,  buf_instr_d;
  logic [PC_WIDTH-1:0]    ifid_pc4_q,   ifid_pc4_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic                   ifid_valid_q, ifid_valid_d;

  logic                adv;
  logic                ack;
  logic [PC_WIDTH-1:0] pc_plus4;

  // A mismatched PCWrite/IF_ID_Write pair is treated as a stall.
  assign adv      = PCWrite & IF_ID_Write;
  assign imem_req = (state_q == FETCH) || (state_q == DROP);
  // An acknowledge with no request outstanding is ignored.
  assign ack      = imem_ack & imem_req;
  // Wraps modulo 2^PC_WIDTH.
  assign pc_plus4 = pc_q + PC_WIDTH'(4);

  // In DROP the PC still holds the squashed address, so the request address
  // stays stable until the stale acknowledge arrives.
  assign imem_addr = pc_q;

  assign IF_PC       = pc_q;
  assign IF_ID_PC4   = ifid_pc4_q;
  assign IF_ID_Instr = ifid_instr_q;
  assign IF_ID_Valid = ifid_valid_q;

  // Next-state decode. A flush always clears IF/ID, whatever IF_ID_Write is,
  // and takes priority over both the stall and the acknowledge. The IF/ID
  // register is written below only on the non-flush paths.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = redirect_q;
    buf_pc4_d    = buf_pc4_q;
    buf_instr_d  = buf_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;

    if (IF_Flush) begin
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end

    unique case (state_q)
      START: begin
        state_d = FETCH;
        if (IF_Flush) begin
          pc_d = branch_target;
        end else if (adv) begin
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end
      end

      FETCH: begin
        if (IF_Flush) begin
          if (ack) begin
            pc_d = branch_target;
          end else begin
            redirect_d = branch_target;
            state_d    = DROP;
          end
        end else if (ack) begin
          if (adv) begin
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4;
          end else begin
            buf_pc4_d   = pc_plus4;
            buf_instr_d = imem_rdata;
            state_d     = HOLD;
          end
        end else if (adv) begin
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (IF_Flush) begin
          pc_d    = branch_target;
          state_d = FETCH;
        end else if (adv) begin
          ifid_pc4_d   = buf_pc4_q;
          ifid_instr_d = buf_instr_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
          state_d      = FETCH;
        end
      end

      DROP: begin
        // A second flush replaces the pending redirect: the latest target
        // wins, even when it coincides with the stale acknowledge.
        if (IF_Flush) begin
          if (ack) begin
            pc_d    = branch_target;
            state_d = FETCH;
          end else begin
            redirect_d = branch_target;
          end
        end else begin
          if (ack) begin
            pc_d    = redirect_q;
            state_d = FETCH;
          end
          if (adv) begin
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = START;
      end
    endcase
  end

  // State and pipeline registers. An asynchronous reset abandons any
  // outstanding request by returning to START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= START;
      pc_q         <= RESET_PC;
      redirect_q   <= '0;
      buf_pc4_q    <= '0;
      buf_instr_q  <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      buf_pc4_q    <= buf_pc4_d;
      buf_instr_q  <= buf_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Self-checking bench for if_fetch_stage. A memory model answers requests
// after a chosen latency with address-derived words. A transaction-level
// reference model tracks which instruction should be delivered next, whether
// one is parked waiting for the pipeline, and whether the outstanding request
// has been squashed.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_Flush;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] IF_PC;
  logic [31:0] IF_ID_PC4;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;

  int assertCount = 0;
  int failCount   = 0;

  // Memory environment
  int latency   = 1;
  int curLat    = 1;
  int waitCnt   = 0;
  bit randomLat = 1'b0;

  // Reference model
  bit          mStarted;
  bit          mHaveBuf;
  bit          mDiscard;
  logic [31:0] mPc;
  logic [31:0] mRedirect;
  logic [31:0] mBufPc4;
  logic [31:0] mBufInstr;
  logic [31:0] mIdPc4;
  logic [31:0] mIdInstr;
  bit          mIdValid;

  if_fetch_stage #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .IF_Flush      (IF_Flush),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ack      (imem_ack),
    .IF_PC         (IF_PC),
    .IF_ID_PC4     (IF_ID_PC4),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_Valid   (IF_ID_Valid)
  );

  always #5 clk = ~clk;

  // Address-derived instruction word; never zero, so it cannot look like a bubble.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[31:18], 2'b11};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("IF_PC", IF_PC, mPc);
    checkOutput("IF_ID_PC4", IF_ID_PC4, mIdPc4);
    checkOutput("IF_ID_Instr", IF_ID_Instr, mIdInstr);
    checkOutput("IF_ID_Valid", {31'b0, IF_ID_Valid}, {31'b0, mIdValid});
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, (mStarted && !mHaveBuf)});
    if (mStarted && !mHaveBuf)
      checkOutput("imem_addr", imem_addr, mPc);
  endtask

  task automatic modelReset();
    mStarted  = 1'b0;
    mHaveBuf  = 1'b0;
    mDiscard  = 1'b0;
    mPc       = 32'h0;
    mRedirect = 32'h0;
    mBufPc4   = 32'h0;
    mBufInstr = 32'h0;
    mIdPc4    = 32'h0;
    mIdInstr  = 32'h0;
    mIdValid  = 1'b0;
  endtask

  // One clock of the reference model, given this cycle's inputs.
  task automatic modelStep(input bit adv, input bit fl, input logic [31:0] tgt,
                           input bit ack);
    bit          req;
    bit          ackEff;
    bit          haveDeliv;
    logic [31:0] dPc4;
    logic [31:0] dInstr;

    req       = mStarted && !mHaveBuf;
    ackEff    = ack && req;
    haveDeliv = 1'b0;
    dPc4      = 32'h0;
    dInstr    = 32'h0;
    if (mHaveBuf) begin
      haveDeliv = 1'b1;
      dPc4      = mBufPc4;
      dInstr    = mBufInstr;
    end else if (ackEff && !mDiscard) begin
      haveDeliv = 1'b1;
      dPc4      = mPc + 32'd4;
      dInstr    = memWord(mPc);
    end

    // Decode-side view
    if (fl) begin
      mIdInstr = 32'h0;
      mIdValid = 1'b0;
    end else if (adv) begin
      if (haveDeliv) begin
        mIdPc4   = dPc4;
        mIdInstr = dInstr;
        mIdValid = 1'b1;
      end else begin
        mIdInstr = 32'h0;
        mIdValid = 1'b0;
      end
    end

    // Fetch-side view
    if (!mStarted) begin
      if (fl) mPc = tgt;
    end else if (fl) begin
      if (mHaveBuf) begin
        mHaveBuf = 1'b0;
        mPc      = tgt;
      end else if (ackEff) begin
        mDiscard = 1'b0;
        mPc      = tgt;
      end else begin
        mDiscard  = 1'b1;
        mRedirect = tgt;
      end
    end else if (mDiscard) begin
      if (ackEff) begin
        mDiscard = 1'b0;
        mPc      = mRedirect;
      end
    end else if (mHaveBuf) begin
      if (adv) begin
        mHaveBuf = 1'b0;
        mPc      = mPc + 32'd4;
      end
    end else if (ackEff) begin
      if (adv) begin
        mPc = mPc + 32'd4;
      end else begin
        mHaveBuf  = 1'b1;
        mBufPc4   = mPc + 32'd4;
        mBufInstr = memWord(mPc);
      end
    end
    mStarted = 1'b1;
  endtask

  // Called at a falling edge: check, drive one cycle of inputs, clock.
  task automatic applyStimulus(input bit pw, input bit iw, input bit fl,
                               input logic [31:0] tgt);
    bit ackNow;
    checkAll();
    PCWrite       = pw;
    IF_ID_Write   = iw;
    IF_Flush      = fl;
    branch_target = tgt;
    if (imem_req === 1'b1) begin
      if (waitCnt == 0) curLat = randomLat ? int'($urandom_range(1, 3)) : latency;
      ackNow  = (waitCnt + 1 >= curLat);
      waitCnt = ackNow ? 0 : waitCnt + 1;
    end else begin
      waitCnt = 0;
      ackNow  = randomLat && ($urandom_range(0, 3) == 0);
    end
    imem_ack   = ackNow;
    imem_rdata = ackNow ? memWord(imem_addr) : $urandom;
    modelStep(pw && iw, fl, tgt, ackNow);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse starting between edges; outputs must clear at once.
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_IF_PC", IF_PC, 32'h0);
    checkOutput("rst_IF_ID_PC4", IF_ID_PC4, 32'h0);
    checkOutput("rst_IF_ID_Instr", IF_ID_Instr, 32'h0);
    checkOutput("rst_IF_ID_Valid", {31'b0, IF_ID_Valid}, 32'h0);
    checkOutput("rst_imem_req", {31'b0, imem_req}, 32'h0);
    modelReset();
    waitCnt  = 0;
    imem_ack = 1'b0;
    IF_Flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runTo(input logic [31:0] pc, input string tag);
    for (int i = 0; i < 40 && IF_PC !== pc; i++) applyStimulus(1, 1, 0, 32'h0);
    checkOutput(tag, IF_PC, pc);
  endtask

  initial begin
    rst_n         = 1'b0;
    PCWrite       = 1'b0;
    IF_ID_Write   = 1'b0;
    IF_Flush      = 1'b0;
    branch_target = 32'h0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    modelReset();
    @(negedge clk);
    doReset();

    // Zero-wait streaming, then a one-cycle load-use stall at pc 0x10
    latency = 1;
    runTo(32'h10, "reachPc10");
    applyStimulus(0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    applyStimulus(1, 1, 0, 32'h0);

    // Three-cycle memory: bubbles between instructions
    latency = 3;
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 32'h0);

    // Flush to 0x100 while the 0x20 fetch is outstanding
    doReset();
    latency = 1;
    runTo(32'h20, "reachPc20");
    latency = 3;
    applyStimulus(1, 1, 0, 32'h0);
    applyStimulus(1, 1, 1, 32'h100);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 32'h0);

    // Flush and stall in the same cycle
    latency = 1;
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 32'h0);
    applyStimulus(1, 0, 1, 32'h200);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 32'h0);

    // Reset mid-request with pc at the top of the address space
    applyStimulus(1, 1, 1, 32'hFFFF_FFFC);
    latency = 3;
    applyStimulus(1, 1, 0, 32'h0);
    checkOutput("topPc", IF_PC, 32'hFFFF_FFFC);
    doReset();

    // PC wrap past 0xFFFFFFFC
    latency = 1;
    applyStimulus(1, 1, 0, 32'h0);
    applyStimulus(1, 1, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 32'h0);

    // Randomised traffic: stalls, flushes, variable latency, stray acks, resets
    randomLat = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                        : ($urandom & 32'h0000_FFFC);
      if ($urandom_range(0, 149) == 0)
        doReset();
      else
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 11) == 0, tgt);
    end
    checkAll();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the hazard detection unit and the ID stage, and consumes the hazard unit's PCWrite/IF_ID_Write stall controls and the ID-stage branch flush. It owns the PC and drives a variable-latency instruction-memory req/ack interface. It delivers PC+4 and the instruction to ID, inserting bubbles whenever no fetched instruction is available.

Parameters:
PC_WIDTH, 32, PC and memory address width
INSTR_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
PCWrite  in  1  from hazard unit; 0 = freeze PC
IF_ID_Write  in  1  from hazard unit; 0 = hold IF/ID register
IF_Flush  in  1  branch/jump taken in ID; squash fetch, redirect PC
branch_target  in  PC_WIDTH  redirect address, valid with IF_Flush
imem_req  out  1  fetch request
imem_addr  out  PC_WIDTH  fetch address
imem_rdata  in  INSTR_WIDTH  instruction, valid with imem_ack
imem_ack  in  1  one-cycle completion strobe for the current request
IF_PC  out  PC_WIDTH  current PC register
IF_ID_PC4  out  PC_WIDTH  PC+4 of the instruction held in IF/ID
IF_ID_Instr  out  INSTR_WIDTH  instruction in IF/ID; 0 (nop) for a bubble
IF_ID_Valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; IF_ID_PC4=0; IF_ID_Instr=0; IF_ID_Valid=0.
  - Buffer cleared; state=START; imem_req=0.
- Advance condition: adv = PCWrite & IF_ID_Write. A mismatched pair is treated as a stall.
- All registers update on the rising edge of clk. Outputs are registered, except imem_req and imem_addr, which are decoded from state.
- States:
  - START: req=0. Next cycle -> FETCH.
  - FETCH: req=1, addr=pc. addr is stable until ack.
  - HOLD: req=0. An acked instruction is parked in the buffer, waiting for adv.
  - DROP: req=1, addr=stale pc. The request is still outstanding after a flush; its returning data is discarded.
- FETCH:
  - flush & ack: discard data; pc<=branch_target; stay FETCH.
  - flush & !ack: redirect_reg<=branch_target -> DROP.
  - ack & adv: IF/ID<={pc+4, imem_rdata, 1}; pc<=pc+4; stay FETCH. Back-to-back fetches give 1 instruction/cycle with zero-wait memory.
  - ack & !adv: buffer<={pc+4, rdata} -> HOLD.
  - no ack & adv: bubble into IF/ID (Instr=0, Valid=0, PC4 unchanged).
  - no ack & !adv: IF/ID holds.
- HOLD:
  - flush: buffer discarded; pc<=branch_target -> FETCH.
  - adv: IF/ID<=buffer, Valid=1; pc<=pc+4 -> FETCH.
  - else: stay.
- DROP:
  - on ack: discard; pc<=redirect_reg -> FETCH.
  - A further flush while in DROP overwrites redirect_reg (latest target wins).
- Flush vs IF/ID:
  - IF_Flush=1 forces IF_ID_Instr<=0 and IF_ID_Valid<=0 that edge, regardless of IF_ID_Write.
  - Flush has priority over stall and over ack.
- pc+4 wraps modulo 2^PC_WIDTH; no overflow flag.
- Reset asserted mid-request: state returns to START and the request is abandoned. The memory model must tolerate a dropped req.
- An imem_ack while req=0 is ignored.
- Latency: instruction visible on IF_ID_* one cycle after its ack when adv is held high.

Test Plan:
- Reset release, 0-wait memory returning addr-derived words, adv=1 -> imem_addr 0,4,8,... one per cycle; IF_ID_PC4 4,8,12,... with Valid=1 one cycle after each ack; IF_ID_Instr matches the word returned for that address.
- Load-use stall: PCWrite=IF_ID_Write=0 for 1 cycle while at pc=0x10 -> IF_ID holds the 0x0C instruction; instruction at 0x10 stays in HOLD; it is released the next cycle; no instruction lost or duplicated.
- 3-cycle memory latency, adv=1 -> two bubble cycles (Instr=0, Valid=0) between valid instructions; imem_addr stable while req=1.
- IF_Flush with target 0x100 during an outstanding 3-cycle fetch of 0x20 -> state DROP; 0x20 data discarded; next req addr=0x100; IF_ID_Valid=0 on the flush edge.
- Flush and stall in the same cycle (IF_ID_Write=0, IF_Flush=1) -> IF_ID_Valid=0 and Instr=0; pc<=target.
- rst_n pulsed low mid-request and again with pc=0xFFFFFFFC -> all outputs return to reset values immediately; separately, pc wraps to 0x0 after fetching 0xFFFFFFFC.
